prt_dp_lib_hpd: RTL and testbench
=================================

Name: prt_dp_lib_hpd

Overview:
- Hot-plug-detect qualifier for the DP source policy/AUX controller.
- Sits directly downstream of the HPD single-bit synchronizer (prt_dp_lib_cdc_bit). It consumes the already synchronized HPD level in the link/control clock domain.
- Debounces plug events, classifies low pulses into glitch, IRQ_HPD and unplug, and reports the connection state and the last measured low duration.

Parameters:
- P_US_CYCLES, 100, clock cycles per microsecond tick (prescaler modulus); must be ≥2.
- P_PLUG_US, 2000, continuous-high time in µs required to declare connected.
- P_IRQ_MIN_US, 250, minimum low duration in µs qualifying as IRQ_HPD; shorter is a glitch.
- P_UNPLUG_US, 2000, low duration in µs at which unplug is declared.
- Constraints: P_IRQ_MIN_US < P_UNPLUG_US. All µs parameters are ≤ 65535.

Ports:
- CLK_IN  in  1  control clock.
- RST_IN  in  1  reset; synchronous, active-high.
- HPD_IN  in  1  synchronized HPD level (1 = high).
- HPD_STA_OUT  out  1  qualified connection state (1 = connected).
- PLUG_OUT  out  1  one-cycle pulse on connect.
- UNPLUG_OUT  out  1  one-cycle pulse on disconnect.
- IRQ_OUT  out  1  one-cycle pulse on a qualified IRQ_HPD.
- LOW_US_OUT  out  16  duration in µs of the last completed or terminated low pulse while connected.

Behaviour:
- Reset:
  - While RST_IN=1 at a clock edge: state=UNPLUGGED, prescaler=0, µs counter=0.
  - All outputs are 0, including LOW_US_OUT=0.
  - Reset has priority over every other event and aborts any measurement in progress. No pulse is emitted on reset exit.
- Time base:
  - The prescaler counts 0..P_US_CYCLES-1. A tick occurs at an edge where prescaler = P_US_CYCLES-1; the prescaler then wraps to 0.
  - Each tick increments the 16-bit µs counter, which saturates at 0xFFFF.
  - Prescaler and counter are both cleared at every state transition edge. Consequently the counter equals N after edge N·P_US_CYCLES, counted from the transition edge (edge 0).
- States:
  - UNPLUGGED:
    - HPD_IN=1 → PLUG_WAIT.
  - PLUG_WAIT:
    - HPD_IN=0 → UNPLUGGED, no output.
    - Otherwise, when counter ≥ P_PLUG_US → CONNECTED. HPD_STA_OUT←1 and PLUG_OUT pulses in the same edge.
  - CONNECTED:
    - HPD_IN=0 → LOW.
  - LOW (evaluated in this order):
    - (a) counter ≥ P_UNPLUG_US → UNPLUGGED, UNPLUG_OUT pulse, HPD_STA_OUT←0, LOW_US_OUT←counter. Rule (a) wins even if HPD_IN=1 in the same cycle.
    - (b) else if HPD_IN=1 and counter ≥ P_IRQ_MIN_US → CONNECTED, IRQ_OUT pulse, LOW_US_OUT←counter.
    - (c) else if HPD_IN=1 → CONNECTED with no pulse (glitch), LOW_US_OUT←counter.
- Output registers and timing:
  - All outputs are registered and change on the same edge as the state register.
  - Decision latency is 1 cycle after the condition becomes true.
  - Plug timing: PLUG_OUT asserts after edge P_PLUG_US·P_US_CYCLES+1, counted from the edge that first samples HPD_IN=1.
- Pulse rules:
  - PLUG_OUT, UNPLUG_OUT and IRQ_OUT are mutually exclusive.
  - Each is high for exactly one cycle, then returns to 0.
- HPD_STA_OUT:
  - Is 1 in CONNECTED and LOW.
  - Is 0 in UNPLUGGED and PLUG_WAIT.
- Boundaries:
  - A low pulse of exactly P_IRQ_MIN_US is an IRQ.
  - Any HPD_IN drop during PLUG_WAIT restarts debounce from 0 on the next rise.
  - LOW_US_OUT holds its value until the next low pulse ends.

Test Plan (P_US_CYCLES=4, P_PLUG_US=8, P_IRQ_MIN_US=3, P_UNPLUG_US=20):
- Assert RST_IN 5 cycles with HPD_IN=1, then release → all outputs 0 during reset. PLUG_OUT pulses once, 33 cycles after the first post-reset edge sampling HPD_IN=1.
- From UNPLUGGED, HPD_IN high 20 cycles, low 2, then high continuously → no PLUG_OUT at the first attempt. PLUG_OUT and HPD_STA_OUT=1 occur 33 cycles after the second rise.
- CONNECTED, HPD_IN low 8 cycles then high → no IRQ_OUT, HPD_STA_OUT stays 1, LOW_US_OUT=2.
- CONNECTED, low 12 cycles, then low 40 cycles → first low: IRQ_OUT one-cycle pulse, LOW_US_OUT=3. Second low: second IRQ pulse, LOW_US_OUT=10.
- CONNECTED, low 100 cycles → UNPLUG_OUT pulses after edge 81, HPD_STA_OUT=0, LOW_US_OUT=20. HPD_IN rising at edge 81 still yields UNPLUG and no IRQ; the following high starts PLUG_WAIT.
- CONNECTED, low 40 cycles with RST_IN pulsed at cycle 20, then HPD_IN high → no IRQ/UNPLUG pulse, HPD_STA_OUT=0 and LOW_US_OUT=0 after reset. PLUG_OUT appears 33 cycles after the first post-reset edge sampling HPD_IN=1.

Source files
------------

// File: rtl/prt_dp_lib_hpd.sv
// HPD qualifier: debounces plug events and classifies low pulses as glitch, IRQ_HPD or unplug.
// Consumes the already synchronized HPD level in the control clock domain.
module prt_dp_lib_hpd #(
  parameter int unsigned P_US_CYCLES  = 100,
  parameter int unsigned P_PLUG_US    = 2000,
  parameter int unsigned P_IRQ_MIN_US = 250,
  parameter int unsigned P_UNPLUG_US  = 2000
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        HPD_IN,
  output logic        HPD_STA_OUT,
  output logic        PLUG_OUT,
  output logic        UNPLUG_OUT,
  output logic        IRQ_OUT,
  output logic [15:0] LOW_US_OUT
);

  localparam int unsigned PRE_W = (P_US_CYCLES > 1) ? $clog2(P_US_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(P_US_CYCLES - 1);
  localparam logic [15:0]      PLUG_US    = 16'(P_PLUG_US);
  localparam logic [15:0]      IRQ_MIN_US = 16'(P_IRQ_MIN_US);
  localparam logic [15:0]      UNPLUG_US  = 16'(P_UNPLUG_US);

  typedef enum logic [1:0] {
    ST_UNPLUGGED,
    ST_PLUG_WAIT,
    ST_CONNECTED,
    ST_LOW
  } state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] prescaler, prescaler_nxt;
  logic [15:0]      us_cnt, us_cnt_nxt, us_cnt_inc;
  logic             tick;
  logic             sta_nxt, plug_nxt, unplug_nxt, irq_nxt;
  logic [15:0]      low_us_nxt;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state       <= ST_UNPLUGGED;
      prescaler   <= '0;
      us_cnt      <= '0;
      HPD_STA_OUT <= 1'b0;
      PLUG_OUT    <= 1'b0;
      UNPLUG_OUT  <= 1'b0;
      IRQ_OUT     <= 1'b0;
      LOW_US_OUT  <= '0;
    end else begin
      state       <= state_nxt;
      prescaler   <= prescaler_nxt;
      us_cnt      <= us_cnt_nxt;
      HPD_STA_OUT <= sta_nxt;
      PLUG_OUT    <= plug_nxt;
      UNPLUG_OUT  <= unplug_nxt;
      IRQ_OUT     <= irq_nxt;
      LOW_US_OUT  <= low_us_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sta_nxt    = HPD_STA_OUT;
    plug_nxt   = 1'b0;
    unplug_nxt = 1'b0;
    irq_nxt    = 1'b0;
    low_us_nxt = LOW_US_OUT;

    case (state)
      ST_UNPLUGGED: begin
        if (HPD_IN) state_nxt = ST_PLUG_WAIT;
      end
      ST_PLUG_WAIT: begin
        if (!HPD_IN) begin
          state_nxt = ST_UNPLUGGED;
        end else if (us_cnt >= PLUG_US) begin
          state_nxt = ST_CONNECTED;
          sta_nxt   = 1'b1;
          plug_nxt  = 1'b1;
        end
      end
      ST_CONNECTED: begin
        if (!HPD_IN) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        // A long-enough low is an unplug even if HPD has just come back.
        if (us_cnt >= UNPLUG_US) begin
          state_nxt  = ST_UNPLUGGED;
          sta_nxt    = 1'b0;
          unplug_nxt = 1'b1;
          low_us_nxt = us_cnt;
        end else if (HPD_IN) begin
          state_nxt  = ST_CONNECTED;
          irq_nxt    = (us_cnt >= IRQ_MIN_US);
          low_us_nxt = us_cnt;
        end
      end
      default: begin
        state_nxt = ST_UNPLUGGED;
        sta_nxt   = 1'b0;
      end
    endcase
  end

  // Time base restarts on every state change so each state measures from its entry edge.
  always_comb begin
    tick       = (prescaler == PRE_MAX);
    us_cnt_inc = (tick && (us_cnt != 16'hFFFF)) ? us_cnt + 16'd1 : us_cnt;
    if (state_nxt != state) begin
      prescaler_nxt = '0;
      us_cnt_nxt    = '0;
    end else begin
      prescaler_nxt = tick ? '0 : prescaler + PRE_W'(1);
      us_cnt_nxt    = us_cnt_inc;
    end
  end

endmodule

// File: tb/tb_prt_dp_lib_hpd.sv
// Bench for prt_dp_lib_hpd: pulse scoreboard keyed on edge index, table of low-pulse widths,
// plus hand sequences for plug debounce, unplug boundary and reset during a low pulse.
module tb_prt_dp_lib_hpd;

  localparam int K_PLUG = 0;
  localparam int K_UNPLUG = 1;
  localparam int K_IRQ = 2;

  logic        CLK_IN = 1'b0;
  logic        RST_IN;
  logic        HPD_IN;
  logic        HPD_STA_OUT, PLUG_OUT, UNPLUG_OUT, IRQ_OUT;
  logic [15:0] LOW_US_OUT;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    int          cycle;
    logic        sta;
    logic [15:0] low_us;
  } ev_t;

  typedef struct {
    int          low_cycles;
    bit          exp_irq;
    logic [15:0] exp_low_us;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[7];

  prt_dp_lib_hpd #(
    .P_US_CYCLES (4),
    .P_PLUG_US   (8),
    .P_IRQ_MIN_US(3),
    .P_UNPLUG_US (20)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST_IN     (RST_IN),
    .HPD_IN     (HPD_IN),
    .HPD_STA_OUT(HPD_STA_OUT),
    .PLUG_OUT   (PLUG_OUT),
    .UNPLUG_OUT (UNPLUG_OUT),
    .IRQ_OUT    (IRQ_OUT),
    .LOW_US_OUT (LOW_US_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int cycle, input logic sta, input logic [15:0] low_us);
    ev_t e;
    e.kind = kind;
    e.cycle = cycle;
    e.sta = sta;
    e.low_us = low_us;
    sb.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK_IN);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      edges(1);
      n++;
    end
    checkOutput("drain_timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Every pulse cycle must match the head of the scoreboard, so stray or stretched pulses fail.
  always @(negedge CLK_IN) begin
    int   npulse;
    int   kind;
    ev_t  e;
    npulse = int'(PLUG_OUT) + int'(UNPLUG_OUT) + int'(IRQ_OUT);
    if (npulse != 0) begin
      kind = PLUG_OUT ? K_PLUG : (UNPLUG_OUT ? K_UNPLUG : K_IRQ);
      checkOutput("pulse_exclusive", npulse, 1);
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse_kind", kind, -1);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_kind", kind, e.kind);
        checkOutput("pulse_edge", cyc, e.cycle);
        checkOutput("pulse_sta", int'(HPD_STA_OUT), int'(e.sta));
        checkOutput("pulse_low_us", int'(LOW_US_OUT), int'(e.low_us));
      end
    end
  end

  // Drive a low pulse whose rising level is sampled n+1 edges after the first low sample.
  task automatic applyStimulus(input vec_t v);
    int k;
    k = cyc;
    HPD_IN = 1'b0;
    if (v.exp_irq) push_ev(K_IRQ, k + v.low_cycles + 2, 1'b1, v.exp_low_us);
    edges(v.low_cycles + 1);
    HPD_IN = 1'b1;
    edges(1);
    checkOutput($sformatf("low_us_n%0d", v.low_cycles), int'(LOW_US_OUT), int'(v.exp_low_us));
    checkOutput($sformatf("sta_n%0d", v.low_cycles), int'(HPD_STA_OUT), 1);
    wait_drain(10);
    edges(5);
  endtask

  initial begin
    int k;
    vecs[0] = '{0, 1'b0, 16'd0};
    vecs[1] = '{8, 1'b0, 16'd2};
    vecs[2] = '{11, 1'b0, 16'd2};
    vecs[3] = '{12, 1'b1, 16'd3};
    vecs[4] = '{40, 1'b1, 16'd10};
    vecs[5] = '{3, 1'b0, 16'd0};
    vecs[6] = '{79, 1'b1, 16'd19};

    RST_IN = 1'b1;
    HPD_IN = 1'b1;
    repeat (5) begin
      edges(1);
      checkOutput("reset_outputs",
                  int'({HPD_STA_OUT, PLUG_OUT, UNPLUG_OUT, IRQ_OUT, LOW_US_OUT}), 0);
    end
    RST_IN = 1'b0;
    push_ev(K_PLUG, cyc + 34, 1'b1, 16'd0);
    wait_drain(100);
    checkOutput("connected_after_plug", int'(HPD_STA_OUT), 1);
    edges(5);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Rise exactly on the unplug edge: unplug wins, then the high starts a fresh debounce.
    k = cyc;
    HPD_IN = 1'b0;
    push_ev(K_UNPLUG, k + 82, 1'b0, 16'd20);
    edges(81);
    HPD_IN = 1'b1;
    push_ev(K_PLUG, k + 116, 1'b1, 16'd20);
    wait_drain(150);
    checkOutput("sta_after_replug", int'(HPD_STA_OUT), 1);
    edges(5);

    k = cyc;
    HPD_IN = 1'b0;
    push_ev(K_UNPLUG, k + 82, 1'b0, 16'd20);
    edges(100);
    checkOutput("sta_long_low", int'(HPD_STA_OUT), 0);
    wait_drain(10);

    // Dropout during debounce restarts the plug timer from the second rise.
    k = cyc;
    HPD_IN = 1'b1;
    edges(20);
    checkOutput("sta_plug_wait", int'(HPD_STA_OUT), 0);
    HPD_IN = 1'b0;
    edges(2);
    HPD_IN = 1'b1;
    push_ev(K_PLUG, k + 56, 1'b1, 16'd20);
    wait_drain(100);
    checkOutput("sta_after_debounce", int'(HPD_STA_OUT), 1);
    edges(5);

    HPD_IN = 1'b0;
    edges(20);
    RST_IN = 1'b1;
    edges(1);
    RST_IN = 1'b0;
    checkOutput("sta_after_mid_reset", int'(HPD_STA_OUT), 0);
    checkOutput("low_us_after_mid_reset", int'(LOW_US_OUT), 0);
    edges(19);
    HPD_IN = 1'b1;
    push_ev(K_PLUG, cyc + 34, 1'b1, 16'd0);
    wait_drain(100);
    checkOutput("sta_final", int'(HPD_STA_OUT), 1);
    edges(10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
